// File: rtl/rv32_barrel_hart_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rv32_barrel_hart_scheduler
// Description : Round-robin barrel scheduler. Issues one hart per slot and
//               carries {hart id, valid} tags down a fetch..writeback pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_barrel_hart_scheduler #(
    parameter int NUM_HARTS      = 8,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
    parameter int NUM_STAGES     = 4,
    parameter int RD_STAGE       = 1,
    parameter int WB_STAGE       = NUM_STAGES - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_HARTS-1:0]      start_mask,
    input  logic                      stop,
    input  logic                      stall,
    input  logic                      halt_req,
    input  logic [HART_CNT_WIDTH-1:0] halt_id,
    output logic [HART_CNT_WIDTH-1:0] fetch_hart,
    output logic                      fetch_valid,
    output logic [HART_CNT_WIDTH-1:0] rsa_hart,
    output logic                      rsa_valid,
    output logic [HART_CNT_WIDTH-1:0] rd_hart,
    output logic                      wb_valid,
    output logic [NUM_HARTS-1:0]      hart_active,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [HART_CNT_WIDTH:0]   c_NUM_HARTS = (HART_CNT_WIDTH + 1)'(NUM_HARTS);
    localparam logic [HART_CNT_WIDTH-1:0] c_LAST_ID   = HART_CNT_WIDTH'(NUM_HARTS - 1);

    state_t                      r_state;
    logic [HART_CNT_WIDTH-1:0]   r_cnt;
    logic [NUM_HARTS-1:0]        r_active;
    logic [HART_CNT_WIDTH-1:0]   r_tag_id  [NUM_STAGES];
    logic                        r_tag_vld [NUM_STAGES];

    logic                        w_halt_hit;
    logic [NUM_HARTS-1:0]        w_active_halt;
    logic [HART_CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                        w_fetch_valid;
    logic                        w_drain_done;

    // Out-of-range hart IDs are silently dropped rather than aliased.
    assign w_halt_hit = halt_req && ({1'b0, halt_id} < c_NUM_HARTS);

    always_comb begin
        w_active_halt = r_active;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (w_halt_hit && (halt_id == HART_CNT_WIDTH'(i))) begin
                w_active_halt[i] = 1'b0;
            end
        end
    end

    assign w_cnt_nxt     = (r_cnt == c_LAST_ID) ? '0 : r_cnt + 1'b1;
    assign w_fetch_valid = (r_state == ST_RUN) && r_active[r_cnt] && !stall;

    // Stage 0 always refills with a bubble in DRAIN, so the pipe is empty after
    // this edge when every stage but the last is already clear.
    always_comb begin
        w_drain_done = 1'b1;
        for (int i = 0; i < NUM_STAGES - 1; i++) begin
            if (r_tag_vld[i]) begin
                w_drain_done = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_active <= '0;
        end else begin
            r_active <= w_active_halt;
            if (!stall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && (start_mask != '0)) begin
                            r_state  <= ST_RUN;
                            r_active <= start_mask;
                            r_cnt    <= '0;
                        end
                    end
                    ST_RUN: begin
                        r_cnt <= w_cnt_nxt;
                        if (stop || (w_active_halt == '0)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        r_cnt <= w_cnt_nxt;
                        if (w_drain_done) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_tag_id[i]  <= '0;
                r_tag_vld[i] <= 1'b0;
            end
        end else if (!stall) begin
            r_tag_id[0]  <= r_cnt;
            r_tag_vld[0] <= w_fetch_valid;
            for (int i = 1; i < NUM_STAGES; i++) begin
                r_tag_id[i]  <= r_tag_id[i-1];
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
        end
    end

    assign fetch_hart  = r_cnt;
    assign fetch_valid = w_fetch_valid;
    assign rsa_hart    = r_tag_id[RD_STAGE];
    assign rsa_valid   = r_tag_vld[RD_STAGE];
    assign rd_hart     = r_tag_id[WB_STAGE];
    assign wb_valid    = r_tag_vld[WB_STAGE];
    assign hart_active = r_active;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
